board_render: RTL and testbench

Pixel-source stage that feeds `draw`. It holds the snake game board as a grid of cell codes, written by the game logic, and scans it in step with `vga_timing`. Per pixel it produces the background/board colour and forwards the VGA timing bundle delayed to match. `draw` consumes `vga_out` and `rgb` and overlays text and score on top.

---
 rtl/board_render_if.sv | 28 ++
 rtl/board_render.sv | 263 ++++++++++++++++++++++++++
 tb/tb_board_render.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_render_if.sv
// vga_if: VGA timing bundle shared by vga_timing, board_render and draw.
// src drives the bundle, snk consumes it.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;

    modport src (
        output hcount,
        output vcount,
        output hsync,
        output vsync,
        output hblnk,
        output vblnk
    );

    modport snk (
        input hcount,
        input vcount,
        input hsync,
        input vsync,
        input hblnk,
        input vblnk
    );
endinterface

// File: rtl/board_render.sv
// board_render: snake board RAM scanned in step with vga_timing.
// Ports:
//   clk, rst        pixel clock, async active-low reset
//   vga_in/vga_out  timing bundle in, same bundle delayed 3 cycles
//   rgb             board colour aligned with vga_out
//   wr_en/x/y/cell  cell write from game logic
//   busy            high while the board is being cleared
module board_render #(
    parameter int CELL_SIZE = 32,
    parameter int BOARD_W   = 32,
    parameter int BOARD_H   = 24,
    localparam int XW = (BOARD_W > 1) ? $clog2(BOARD_W) : 1,
    localparam int YW = (BOARD_H > 1) ? $clog2(BOARD_H) : 1
) (
    input  logic          clk,
    input  logic          rst,
    vga_if.snk            vga_in,
    vga_if.src            vga_out,
    output logic [11:0]   rgb,
    input  logic          wr_en,
    input  logic [XW-1:0] wr_x,
    input  logic [YW-1:0] wr_y,
    input  logic [2:0]    wr_cell,
    output logic          busy
);

    localparam int N  = BOARD_W * BOARD_H;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int OW = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
    // cell counters run on through blanking up to the largest hcount
    localparam int CW = $clog2(2048 / CELL_SIZE + 1);

    localparam logic [OW-1:0] OMAX = OW'(CELL_SIZE - 1);
    localparam logic [CW-1:0] BW_C = CW'(BOARD_W);
    localparam logic [CW-1:0] BH_C = CW'(BOARD_H);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } vga_t;

    typedef enum logic [0:0] {
        CLEAR,
        RUN
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] clr_q;
    logic [AW-1:0] clr_d;

    logic [OW-1:0] ox_q;
    logic [OW-1:0] oy_q;
    logic [CW-1:0] cx_q;
    logic [CW-1:0] cy_q;
    logic [OW-1:0] cur_ox;
    logic [OW-1:0] cur_oy;
    logic [CW-1:0] cur_cx;
    logic [CW-1:0] cur_cy;

    vga_t          vin_c;
    logic          in_board_c;
    logic          grid_c;
    logic [AW-1:0] addr_c;

    logic          we_c;
    logic [AW-1:0] wa_c;
    logic [2:0]    wd_c;
    logic          in_range;

    logic [AW-1:0] s1_addr;
    logic          s1_inb;
    logic          s1_grid;
    logic          s1_clr;
    vga_t          s1_vga;

    logic [2:0]    rd_q;
    logic          s2_inb;
    logic          s2_grid;
    logic          s2_clr;
    vga_t          s2_vga;

    vga_t          s3_vga;
    logic [2:0]    code_c;
    logic [11:0]   rgb_c;

    logic [2:0]    mem [N];

    function automatic logic [11:0] cell_rgb(
        input logic [2:0] code,
        input logic       grid
    );
        logic [11:0] c;
        c = 12'h000;
        unique case (code)
            3'd0: c = grid ? 12'h222 : 12'h111;
            3'd1: c = 12'h888;
            3'd2: c = 12'hF00;
            3'd3: c = 12'h0F0;
            3'd4: c = 12'h0A0;
            3'd5: c = 12'h00F;
            3'd6: c = 12'h00A;
            3'd7: c = 12'hF0F;
        endcase
        return c;
    endfunction

    assign busy = (state_q == CLEAR);

    assign vin_c.hcount = vga_in.hcount;
    assign vin_c.vcount = vga_in.vcount;
    assign vin_c.hsync  = vga_in.hsync;
    assign vin_c.vsync  = vga_in.vsync;
    assign vin_c.hblnk  = vga_in.hblnk;
    assign vin_c.vblnk  = vga_in.vblnk;

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        unique case (state_q)
            CLEAR: begin
                clr_d = clr_q + AW'(1);
                if (clr_q == LAST) begin
                    state_d = RUN;
                    clr_d   = '0;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
                clr_d   = '0;
            end
        endcase
    end

    // The registered counters describe the previous pixel; these are
    // the counters for the pixel currently on vga_in.
    always_comb begin
        cur_ox = ox_q;
        cur_cx = cx_q;
        cur_oy = oy_q;
        cur_cy = cy_q;
        if (vga_in.hcount == '0) begin
            cur_ox = '0;
            cur_cx = '0;
            if (vga_in.vcount == '0) begin
                cur_oy = '0;
                cur_cy = '0;
            end else if (oy_q == OMAX) begin
                cur_oy = '0;
                cur_cy = cy_q + CW'(1);
            end else begin
                cur_oy = oy_q + OW'(1);
            end
        end else if (ox_q == OMAX) begin
            cur_ox = '0;
            cur_cx = cx_q + CW'(1);
        end else begin
            cur_ox = ox_q + OW'(1);
        end
    end

    assign in_board_c = (cur_cx < BW_C)
                     && (cur_cy < BH_C)
                     && !vga_in.hblnk
                     && !vga_in.vblnk;

    assign grid_c = (cur_ox == '0) || (cur_oy == '0);

    assign addr_c = AW'(32'(cur_cy) * 32'(BOARD_W)
                      + 32'(cur_cx));

    assign in_range = (32'(wr_x) < 32'(BOARD_W))
                   && (32'(wr_y) < 32'(BOARD_H));

    always_comb begin
        we_c = 1'b0;
        wa_c = '0;
        wd_c = '0;
        if (state_q == CLEAR) begin
            we_c = 1'b1;
            wa_c = clr_q;
        end else if (wr_en && in_range) begin
            we_c = 1'b1;
            wa_c = AW'(32'(wr_y) * 32'(BOARD_W)
                       + 32'(wr_x));
            wd_c = wr_cell;
        end
    end

    // Board RAM, read-first. Not reset: the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem[wa_c] <= wd_c;
        end
        rd_q <= mem[s1_addr];
    end

    // While clearing, stale RAM contents must not reach the screen.
    assign code_c = s2_clr ? 3'd0 : rd_q;

    always_comb begin
        rgb_c = 12'h000;
        if (s2_inb) begin
            rgb_c = cell_rgb(code_c, s2_grid);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR;
            clr_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            s1_addr <= '0;
            s1_inb  <= 1'b0;
            s1_grid <= 1'b0;
            s1_clr  <= 1'b0;
            s1_vga  <= '0;
            s2_inb  <= 1'b0;
            s2_grid <= 1'b0;
            s2_clr  <= 1'b0;
            s2_vga  <= '0;
            s3_vga  <= '0;
            rgb     <= 12'h000;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            ox_q    <= cur_ox;
            oy_q    <= cur_oy;
            cx_q    <= cur_cx;
            cy_q    <= cur_cy;
            s1_addr <= in_board_c ? addr_c : '0;
            s1_inb  <= in_board_c;
            s1_grid <= grid_c;
            s1_clr  <= (state_q == CLEAR);
            s1_vga  <= vin_c;
            s2_inb  <= s1_inb;
            s2_grid <= s1_grid;
            s2_clr  <= s1_clr;
            s2_vga  <= s1_vga;
            s3_vga  <= s2_vga;
            rgb     <= rgb_c;
        end
    end

    assign vga_out.hcount = s3_vga.hcount;
    assign vga_out.vcount = s3_vga.vcount;
    assign vga_out.hsync  = s3_vga.hsync;
    assign vga_out.vsync  = s3_vga.vsync;
    assign vga_out.hblnk  = s3_vga.hblnk;
    assign vga_out.vblnk  = s3_vga.vblnk;

endmodule

// File: tb/tb_board_render.sv
// tb_board_render: directed checks of board_render on a small board
// (5-pixel cells, 6x5 cells, 40x30 frame) driven by a local timing source.
module tb_board_render;

    localparam int CS   = 5;
    localparam int BW   = 6;
    localparam int BH   = 5;
    localparam int N    = BW * BH;
    localparam int HT   = 40;
    localparam int VT   = 30;
    localparam int HACT = 32;
    localparam int VACT = 27;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] rgb;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_x = '0;
    logic [2:0]  wr_y = '0;
    logic [2:0]  wr_cell = '0;
    logic        busy;

    vga_if vin();
    vga_if vout();

    board_render #(
        .CELL_SIZE(CS),
        .BOARD_W(BW),
        .BOARD_H(BH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vga_in(vin),
        .vga_out(vout),
        .rgb(rgb),
        .wr_en(wr_en),
        .wr_x(wr_x),
        .wr_y(wr_y),
        .wr_cell(wr_cell),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int bad = 0;

    logic [2:0]  mem_m [N];
    logic [11:0] expf  [VT][HT];
    logic [11:0] cap   [VT][HT];

    function automatic logic [25:0] vga_bits(input int h, input int v);
        logic hs, vs, hb, vb;
        hs = (h >= 34) && (h < 37);
        vs = (v == 28);
        hb = (h >= HACT);
        vb = (v >= VACT);
        return {11'(h), 11'(v), hs, vs, hb, vb};
    endfunction

    function automatic logic [11:0] colour(input logic [2:0] c, input logic e);
        case (c)
            3'd0:    return e ? 12'h222 : 12'h111;
            3'd1:    return 12'h888;
            3'd2:    return 12'hF00;
            3'd3:    return 12'h0F0;
            3'd4:    return 12'h0A0;
            3'd5:    return 12'h00F;
            3'd6:    return 12'h00A;
            default: return 12'hF0F;
        endcase
    endfunction

    task automatic build_exp();
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                if (h >= HACT || v >= VACT || h / CS >= BW || v / CS >= BH)
                    expf[v][h] = 12'h000;
                else
                    expf[v][h] = colour(mem_m[(v / CS) * BW + h / CS],
                                        (h % CS == 0) || (v % CS == 0));
            end
        end
    endtask

    task automatic drive_pix(input int h, input int v);
        {vin.hcount, vin.vcount, vin.hsync,
         vin.vsync, vin.hblnk, vin.vblnk} = vga_bits(h, v);
    endtask

    task automatic write_cell(input int x, input int y, input int c);
        drive_pix(0, 0);
        wr_en   = 1'b1;
        wr_x    = 3'(x);
        wr_y    = 3'(y);
        wr_cell = 3'(c);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Drives one full frame; optional write strobe at step wr_k.
    task automatic run_frame(input int wr_k, input int wx, input int wy,
                             input int wc, output int b_rgb,
                             output int b_vga, output int b_blank);
        b_rgb = 0;
        b_vga = 0;
        b_blank = 0;
        for (int k = 0; k < HT * VT + 2; k++) begin
            int p;
            p = k % (HT * VT);
            drive_pix(p % HT, p / HT);
            wr_en   = (k == wr_k);
            wr_x    = 3'(wx);
            wr_y    = 3'(wy);
            wr_cell = 3'(wc);
            @(posedge clk);
            #1;
            if (k >= 2) begin
                int q, h, v;
                q = k - 2;
                h = q % HT;
                v = q / HT;
                cap[v][h] = rgb;
                if (rgb !== expf[v][h]) b_rgb++;
                if ({vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                     vout.hblnk, vout.vblnk} !== vga_bits(h, v)) b_vga++;
                if ((vout.hblnk || vout.vblnk) && rgb !== 12'h000) b_blank++;
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_pix(10, 10);
        repeat (4) @(posedge clk);
        #1;
        vec++;
        if (rgb !== 12'h000) begin
            bad++;
            $display("FAIL reset_rgb: got %h want 000", rgb);
        end
        vec++;
        if ({vout.hcount, vout.vcount, vout.hsync, vout.vsync,
             vout.hblnk, vout.vblnk} !== 26'h0) begin
            bad++;
            $display("FAIL reset_vga: got hcount %0d vcount %0d want 0",
                     vout.hcount, vout.vcount);
        end
        vec++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_busy: got %b want 1", busy);
        end
    endtask

    task automatic test_clear_sweep();
        int n;
        n = 0;
        for (int i = 0; i < N; i++) mem_m[i] = 3'd0;
        drive_pix(0, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 2 * N + 10; j++) begin
            wr_en   = (j < 20);
            wr_x    = 3'd1;
            wr_y    = 3'd1;
            wr_cell = 3'd7;
            if (busy === 1'b1) n++;
            @(negedge clk);
        end
        wr_en = 1'b0;
        vec++;
        if (n !== N) begin
            bad++;
            $display("FAIL busy_len: got %0d want %0d", n, N);
        end
        vec++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_end: got %b want 0", busy);
        end
    endtask

    task automatic test_clear_frame();
        int br, bv, bb;
        build_exp();
        run_frame(-1, 0, 0, 0, br, bv, bb);
        vec++;
        if (br !== 0) begin
            bad++;
            $display("FAIL clear_frame_rgb: got %0d bad pixels want 0", br);
        end
        vec++;
        if (bv !== 0) begin
            bad++;
            $display("FAIL clear_frame_vga: got %0d bad samples want 0", bv);
        end
        vec++;
        if (bb !== 0) begin
            bad++;
            $display("FAIL blank_rgb: got %0d lit blank pixels want 0", bb);
        end
        vec++;
        if (cap[0][1] !== 12'h222) begin
            bad++;
            $display("FAIL grid_px: got %h want 222", cap[0][1]);
        end
        vec++;
        if (cap[1][1] !== 12'h111) begin
            bad++;
            $display("FAIL empty_px: got %h want 111", cap[1][1]);
        end
        vec++;
        if (cap[3][30] !== 12'h000) begin
            bad++;
            $display("FAIL off_board_px: got %h want 000", cap[3][30]);
        end
    endtask

    task automatic test_colours();
        int br, bv, bb;
        write_cell(5, 4, 2);
        write_cell(0, 0, 1);
        write_cell(1, 0, 3);
        write_cell(2, 0, 4);
        write_cell(3, 0, 6);
        write_cell(4, 0, 7);
        mem_m[4 * BW + 5] = 3'd2;
        mem_m[0] = 3'd1;
        mem_m[1] = 3'd3;
        mem_m[2] = 3'd4;
        mem_m[3] = 3'd6;
        mem_m[4] = 3'd7;
        build_exp();
        run_frame(-1, 0, 0, 0, br, bv, bb);
        vec++;
        if (br !== 0) begin
            bad++;
            $display("FAIL colour_frame: got %0d bad pixels want 0", br);
        end
        vec++;
        if (cap[20][25] !== 12'hF00) begin
            bad++;
            $display("FAIL food_corner: got %h want F00", cap[20][25]);
        end
        vec++;
        if (cap[22][27] !== 12'hF00) begin
            bad++;
            $display("FAIL food_inner: got %h want F00", cap[22][27]);
        end
        vec++;
        if (cap[2][2] !== 12'h888) begin
            bad++;
            $display("FAIL wall: got %h want 888", cap[2][2]);
        end
        vec++;
        if (cap[0][5] !== 12'h0F0) begin
            bad++;
            $display("FAIL p1_head: got %h want 0F0", cap[0][5]);
        end
        vec++;
        if (cap[2][12] !== 12'h0A0) begin
            bad++;
            $display("FAIL p1_body: got %h want 0A0", cap[2][12]);
        end
        vec++;
        if (cap[2][17] !== 12'h00A) begin
            bad++;
            $display("FAIL p2_body: got %h want 00A", cap[2][17]);
        end
        vec++;
        if (cap[2][22] !== 12'hF0F) begin
            bad++;
            $display("FAIL reserved: got %h want F0F", cap[2][22]);
        end
    endtask

    task automatic test_out_of_range();
        int br, bv, bb;
        write_cell(6, 0, 7);
        write_cell(7, 1, 7);
        write_cell(0, 5, 7);
        build_exp();
        run_frame(-1, 0, 0, 0, br, bv, bb);
        vec++;
        if (br !== 0) begin
            bad++;
            $display("FAIL oor_frame: got %0d bad pixels want 0", br);
        end
        vec++;
        if (cap[7][2] !== 12'h111) begin
            bad++;
            $display("FAIL oor_x6: got %h want 111", cap[7][2]);
        end
        vec++;
        if (cap[12][7] !== 12'h111) begin
            bad++;
            $display("FAIL oor_x7: got %h want 111", cap[12][7]);
        end
    endtask

    task automatic test_collision();
        int br, bv, bb, trig;
        trig = 7 * HT + 12;
        build_exp();
        for (int v = 5; v < 10; v++)
            for (int h = 10; h < 15; h++)
                if (v * HT + h > trig) expf[v][h] = 12'h00F;
        run_frame(trig + 1, 2, 1, 5, br, bv, bb);
        mem_m[1 * BW + 2] = 3'd5;
        vec++;
        if (br !== 0) begin
            bad++;
            $display("FAIL collide_frame: got %0d bad pixels want 0", br);
        end
        vec++;
        if (cap[7][12] !== 12'h111) begin
            bad++;
            $display("FAIL collide_old: got %h want 111", cap[7][12]);
        end
        vec++;
        if (cap[7][13] !== 12'h00F) begin
            bad++;
            $display("FAIL collide_next: got %h want 00F", cap[7][13]);
        end
        vec++;
        if (cap[8][12] !== 12'h00F) begin
            bad++;
            $display("FAIL collide_line: got %h want 00F", cap[8][12]);
        end
    endtask

    task automatic test_mid_reset();
        int br, bv, bb, n;
        for (int k = 0; k <= 12 * HT + 20; k++) begin
            drive_pix(k % HT, k / HT);
            @(posedge clk);
            #1;
        end
        wr_en   = 1'b1;
        wr_x    = 3'd0;
        wr_y    = 3'd0;
        wr_cell = 3'd3;
        rst = 1'b0;
        #1;
        vec++;
        if (rgb !== 12'h000) begin
            bad++;
            $display("FAIL midrst_rgb: got %h want 000", rgb);
        end
        vec++;
        if (vout.hcount !== 11'd0 || vout.vcount !== 11'd0) begin
            bad++;
            $display("FAIL midrst_vga: got %0d,%0d want 0,0",
                     vout.hcount, vout.vcount);
        end
        vec++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_busy: got %b want 1", busy);
        end
        repeat (3) @(posedge clk);
        #1;
        wr_en = 1'b0;
        drive_pix(0, 0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int j = 0; j < 2 * N + 10; j++) begin
            if (busy === 1'b1) n++;
            @(negedge clk);
        end
        vec++;
        if (n !== N) begin
            bad++;
            $display("FAIL midrst_busy_len: got %0d want %0d", n, N);
        end
        for (int i = 0; i < N; i++) mem_m[i] = 3'd0;
        build_exp();
        run_frame(-1, 0, 0, 0, br, bv, bb);
        vec++;
        if (br !== 0) begin
            bad++;
            $display("FAIL midrst_frame: got %0d bad pixels want 0", br);
        end
        vec++;
        if (cap[22][27] !== 12'h111) begin
            bad++;
            $display("FAIL midrst_food: got %h want 111", cap[22][27]);
        end
        vec++;
        if (cap[7][12] !== 12'h222 && cap[7][12] !== 12'h111) begin
            bad++;
            $display("FAIL midrst_head: got %h want 111", cap[7][12]);
        end
    endtask

    initial begin
        drive_pix(0, 0);
        test_reset();
        test_clear_sweep();
        test_clear_frame();
        test_colours();
        test_out_of_range();
        test_collision();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
